// File: rtl/arm7_block_xfer_ctrl.sv
// ARM7 LDM/STM block transfer sequencer: walks the register list in ascending
// order, issuing one word access per register, and handles base writeback.
module arm7_block_xfer_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XFER_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [3:0]        rn,
    input  logic [31:0]       base,
    input  logic              pre,
    input  logic              up,
    input  logic              wb,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [31:0]       rf_wdata
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [3:0]  rn_q, rn_d;
    logic        load_q, load_d;
    logic        wb_q, wb_d;
    logic        first_q, first_d;
    logic        rn_in_q, rn_in_d;
    logic        pend_q, pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wbval_q, wbval_d;

    logic [15:0]       eff_list;
    logic [15:0]       list_rest;
    logic [XFER_W-1:0] cnt;
    logic [31:0]       span;
    logic [31:0]       first_addr;
    logic [3:0]        cur_idx;
    logic              xfer_we;

    // Start-time decode; an empty list becomes R15 only with a 16-word span.
    always_comb begin
        eff_list = (reg_list == 16'h0000) ? 16'h8000 : reg_list;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + XFER_W'(reg_list[i]);
        end
        span = (reg_list == 16'h0000) ? 32'h40 : (32'(cnt) << 2);
        case ({pre, up})
            2'b01:   first_addr = base;
            2'b11:   first_addr = base + 32'd4;
            2'b00:   first_addr = base - span + 32'd4;
            default: first_addr = base - span;
        endcase
    end

    always_comb begin
        cur_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur_idx = 4'(i);
            end
        end
        list_rest = list_q & ~(16'h0001 << cur_idx);
    end

    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        rn_d     = rn_q;
        load_d   = load_q;
        wb_d     = wb_q;
        first_d  = first_q;
        rn_in_d  = rn_in_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        wbval_d  = wbval_q;
        busy     = 1'b0;
        done     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        rf_raddr = 4'd0;
        rf_we    = 1'b0;
        rf_waddr = 4'd0;
        rf_wdata = 32'd0;
        xfer_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = XFER;
                    list_d  = eff_list;
                    rn_d    = rn;
                    load_d  = load;
                    wb_d    = wb;
                    first_d = 1'b1;
                    rn_in_d = eff_list[rn];
                    pend_d  = 1'b0;
                    addr_d  = {first_addr[31:2], 2'b00};
                    wbval_d = up ? (base + span) : (base - span);
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = ~load_q;
                mem_addr = addr_q[ADDR_W-1:0];
                rf_raddr = cur_idx;
                if (mem_ack) begin
                    addr_d  = addr_q + 32'd4;
                    list_d  = list_rest;
                    first_d = 1'b0;
                    if (load_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = cur_idx;
                        rf_wdata = mem_rdata;
                        xfer_we  = 1'b1;
                    end
                    // A load owns the write port this cycle, so its writeback is deferred.
                    if (first_q && wb_q && !(load_q && rn_in_q)) begin
                        if (load_q) begin
                            pend_d = 1'b1;
                        end else begin
                            rf_we    = 1'b1;
                            rf_waddr = rn_q;
                            rf_wdata = wbval_q;
                        end
                    end
                    if (list_rest == 16'h0000) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pend_q && !xfer_we) begin
            rf_we    = 1'b1;
            rf_waddr = rn_q;
            rf_wdata = wbval_q;
            pend_d   = 1'b0;
        end
    end

    assign mem_wdata = rf_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            list_q  <= 16'h0000;
            rn_q    <= 4'd0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            first_q <= 1'b0;
            rn_in_q <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= 32'd0;
            wbval_q <= 32'd0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            rn_q    <= rn_d;
            load_q  <= load_d;
            wb_q    <= wb_d;
            first_q <= first_d;
            rn_in_q <= rn_in_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            wbval_q <= wbval_d;
        end
    end
endmodule

// File: tb/tb_arm7_block_xfer_ctrl.sv
// Self-checking bench for arm7_block_xfer_ctrl: directed cases plus randomized
// transfers against a transaction-level model of LDM/STM behaviour.
module tb_arm7_block_xfer_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] reg_list;
   logic [3:0]  rn;
   logic [31:0] base;
   logic        pre, up, wb, load;
   logic        busy, done, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [3:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int failures = 0;

   // Register file and bus-activity counters seen by the DUT
   logic [31:0] rf [16];
   logic [31:0] rfInit [16];
   logic        benchClear = 1'b0;
   int          rfWrites = 0;
   int          memWrites = 0;

   always #5 clk = ~clk;

   arm7_block_xfer_ctrl #(.ADDR_W(32), .XFER_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .reg_list(reg_list), .rn(rn),
      .base(base), .pre(pre), .up(up), .wb(wb), .load(load), .busy(busy),
      .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   assign rf_rdata = rf[rf_raddr];

   // Register file updates and write counting, with a bench-controlled preload
   always @(posedge clk) begin
      if (benchClear) begin
         for (int i = 0; i < 16; i++) rf[i] <= rfInit[i];
         rfWrites  <= 0;
         memWrites <= 0;
      end else begin
         if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            rfWrites <= rfWrites + 1;
         end
         if (mem_req && mem_we && mem_ack) memWrites <= memWrites + 1;
      end
   end

   // Single comparison point: every check flows through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Runs one complete transfer; the model is built from the list/flags up front
   task automatic applyStimulus(input logic [15:0] list, input logic [3:0] rnI,
                                input bit p, input bit u, input bit w, input bit l,
                                input int waitMin, input int waitMax,
                                input logic [31:0] ldFixed, input bit useLit,
                                input logic [31:0] litAddr, input logic [31:0] litRn,
                                input int litDone);
      int          beatReg [16];
      logic [31:0] ldData [16];
      logic [31:0] expStore [16];
      logic [31:0] expRf [16];
      int          n;
      logic [31:0] span, baseV, firstAddr, wbVal;
      bit          rnIn;
      int          expWrites;
      int          beat, waitCnt, cyc, guard;
      logic [15:0] effList;

      baseV   = rfInit[rnI];
      effList = (list == 16'h0) ? 16'h8000 : list;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (effList[i]) begin
            beatReg[n] = i;
            n++;
         end
      end
      span = (list == 16'h0) ? 32'h40 : 32'(4 * n);
      if (u) firstAddr = p ? baseV + 4 : baseV;
      else   firstAddr = p ? baseV - span : baseV - span + 4;
      wbVal = u ? baseV + span : baseV - span;
      rnIn  = effList[rnI];

      for (int i = 0; i < 16; i++) expRf[i] = rfInit[i];
      for (int k = 0; k < n; k++) begin
         ldData[k] = (ldFixed != 0) ? ldFixed : $urandom;
         expStore[k] = (w && beatReg[k] == int'(rnI) && k > 0) ? wbVal : rfInit[beatReg[k]];
         if (l) expRf[beatReg[k]] = ldData[k];
      end
      if (w && !(l && rnIn)) expRf[rnI] = wbVal;
      expWrites = l ? n + ((w && !rnIn) ? 1 : 0) : (w ? 1 : 0);

      @(posedge clk); #1;
      benchClear = 1'b1;
      @(posedge clk); #1;
      benchClear = 1'b0;
      start = 1'b1; reg_list = list; rn = rnI; base = baseV;
      pre = p; up = u; wb = w; load = l;
      #1;
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      reg_list = 16'($urandom);
      cyc = 1;
      beat = 0;
      guard = 0;
      waitCnt = $urandom_range(waitMax, waitMin);
      while (beat < n && guard < 2000) begin
         mem_ack   = (waitCnt == 0);
         mem_rdata = (waitCnt == 0) ? ldData[beat] : $urandom;
         #1;
         checkOutput("xfer_req", 32'(mem_req), 32'd1);
         checkOutput("xfer_busy", 32'(busy), 32'd1);
         checkOutput("xfer_done", 32'(done), 32'd0);
         checkOutput("xfer_we", 32'(mem_we), 32'(!l));
         checkOutput("xfer_addr", mem_addr, (firstAddr + 32'(4 * beat)) & 32'hFFFF_FFFC);
         checkOutput("xfer_raddr", 32'(rf_raddr), 32'(beatReg[beat]));
         if (useLit && beat == 0) checkOutput("lit_first_addr", mem_addr, litAddr);
         if (waitCnt == 0) begin
            if (l) begin
               checkOutput("ld_rf_we", 32'(rf_we), 32'd1);
               checkOutput("ld_rf_waddr", 32'(rf_waddr), 32'(beatReg[beat]));
               checkOutput("ld_rf_wdata", rf_wdata, ldData[beat]);
            end else begin
               checkOutput("st_wdata", mem_wdata, expStore[beat]);
            end
            beat++;
            waitCnt = $urandom_range(waitMax, waitMin);
         end else begin
            waitCnt--;
            if (!l) checkOutput("st_wait_rf_we", 32'(rf_we), 32'd0);
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         cyc++;
         guard++;
      end
      if (guard >= 2000) checkOutput("timeout_beats", 32'(beat), 32'(n));
      #1;
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_req", 32'(mem_req), 32'd0);
      if (litDone >= 0) checkOutput("lit_done_cycle", 32'(cyc), 32'(litDone));
      @(posedge clk); #1;
      checkOutput("post_done", 32'(done), 32'd0);
      checkOutput("post_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("rf_final_r%0d", i), rf[i], expRf[i]);
      checkOutput("rf_write_count", 32'(rfWrites), 32'(expWrites));
      if (useLit) checkOutput("lit_rn_final", rf[rnI], litRn);
   endtask

   task automatic randomRf();
      for (int i = 0; i < 16; i++) rfInit[i] = $urandom;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; reg_list = 16'h0; rn = 4'd0; base = 32'd0;
      pre = 1'b0; up = 1'b0; wb = 1'b0; load = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
      randomRf();
      #2;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;

      // STMIA {R1,R3} base 0x100 with writeback
      randomRf(); rfInit[0] = 32'h100;
      applyStimulus(16'h000A, 4'd0, 0, 1, 1, 0, 0, 0, 32'd0, 1, 32'h100, 32'h108, 3);
      // LDMDB {R0,R15} base 0x200
      randomRf(); rfInit[1] = 32'h200;
      applyStimulus(16'h8001, 4'd1, 1, 0, 1, 1, 0, 0, 32'd0, 1, 32'h1F8, 32'h1F8, 3);
      // Empty list, LDMIA then LDMDB
      randomRf(); rfInit[2] = 32'h1000;
      applyStimulus(16'h0000, 4'd2, 0, 1, 1, 1, 0, 0, 32'd0, 1, 32'h1000, 32'h1040, 2);
      randomRf(); rfInit[2] = 32'h1000;
      applyStimulus(16'h0000, 4'd2, 1, 0, 1, 1, 0, 0, 32'd0, 1, 32'hFC0, 32'hFC0, 2);
      // STMIA with Rn in the list, not lowest then lowest
      randomRf(); rfInit[2] = 32'h300;
      applyStimulus(16'h0006, 4'd2, 0, 1, 1, 0, 0, 0, 32'd0, 1, 32'h300, 32'h308, 3);
      randomRf(); rfInit[2] = 32'h300;
      applyStimulus(16'h0024, 4'd2, 0, 1, 1, 0, 0, 0, 32'd0, 1, 32'h300, 32'h308, 3);
      // LDMIA {R4} base register R4, three wait cycles per beat
      randomRf(); rfInit[4] = 32'h400;
      applyStimulus(16'h0010, 4'd4, 0, 1, 1, 1, 3, 3, 32'hDEAD, 1, 32'h400, 32'hDEAD, 5);
      // Four-register LDMIA with waits, zero-wait-free latency pin
      randomRf(); rfInit[6] = 32'h800;
      applyStimulus(16'h0F00, 4'd6, 0, 1, 1, 1, 3, 3, 32'd0, 1, 32'h800, 32'h810, 17);

      // Reset during the second beat of a four-register STM
      randomRf(); rfInit[0] = 32'h2000;
      @(posedge clk); #1; benchClear = 1'b1;
      @(posedge clk); #1; benchClear = 1'b0;
      start = 1'b1; reg_list = 16'h001E; rn = 4'd0; base = 32'h2000;
      pre = 1'b0; up = 1'b1; wb = 1'b0; load = 1'b0;
      @(posedge clk); #1; start = 1'b0; mem_ack = 1'b1;
      #1; checkOutput("rst_mid_addr0", mem_addr, 32'h2000);
      @(posedge clk); #1; mem_ack = 1'b0;
      #1; checkOutput("rst_mid_addr1", mem_addr, 32'h2004);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_rf_we", 32'(rf_we), 32'd0);
      checkOutput("rst_mid_addr", mem_addr, 32'd0);
      mem_ack = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      checkOutput("rst_mid_memwrites", 32'(memWrites), 32'd1);
      checkOutput("rst_mid_rfwrites", 32'(rfWrites), 32'd0);
      checkOutput("rst_mid_req_hold", 32'(mem_req), 32'd0);
      mem_ack = 1'b0;
      rst_n = 1'b1;
      randomRf(); rfInit[0] = 32'h100;
      applyStimulus(16'h000A, 4'd0, 0, 1, 1, 0, 0, 0, 32'd0, 1, 32'h100, 32'h108, 3);

      // Randomized transfers
      for (int t = 0; t < 40; t++) begin
         logic [15:0] rl;
         logic [3:0]  rr;
         randomRf();
         rl = ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom);
         rr = 4'($urandom);
         applyStimulus(rl, rr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       0, 2, 32'd0, 0, 32'd0, 32'd0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
